// File: rtl/cmd_pulse_pkg.sv
// Shared definitions for the command-triggered multi-channel pulse generator.
// Holds the per-channel FSM state encoding used by cmd_pulse_chan.
package cmd_pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_ACTIVE = 2'd2
   } chan_state_t;

endpackage : cmd_pulse_pkg

// File: rtl/cmd_pulse_chan.sv
// One pulse channel: a matching command starts DLY idle cycles, then LEN cycles of Pulse_Out.
// Outputs are registered (first effect one edge after the hit); there is no backpressure, so a hit while busy restarts or is dropped.
module cmd_pulse_chan
   import cmd_pulse_pkg::*;
#(
   parameter int               CMD_W  = 16,
   parameter int               CNT_W  = 8,
   parameter logic [CMD_W-1:0] CODE   = '0,
   parameter logic [CNT_W-1:0] LEN    = CNT_W'(10),
   parameter logic [CNT_W-1:0] DLY    = '0,
   parameter logic             RETRIG = 1'b0
) (
   input  logic             Clk_In,
   input  logic             Rst,
   input  logic [CMD_W-1:0] Cmd_In,
   input  logic             Cmd_En,
   input  logic             Flag_Clr,
   output logic             Pulse_Out,
   output logic             Busy,
   output logic             Drop_Flag
);

   // A zero length still produces a single-cycle pulse.
   localparam logic [CNT_W-1:0] LEN_EFF  = (LEN == '0) ? CNT_W'(1) : LEN;
   localparam logic [CNT_W-1:0] LEN_LOAD = LEN_EFF - CNT_W'(1);
   localparam logic             DLY_ZERO = (DLY == '0);
   localparam logic [CNT_W-1:0] DLY_LOAD = DLY_ZERO ? '0 : (DLY - CNT_W'(1));

   chan_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic             hit;
   logic             load;
   logic             drop_set;

   assign hit      = Cmd_En && (Cmd_In == CODE);
   assign load     = hit && ((state == ST_IDLE) || RETRIG);
   assign drop_set = hit && !RETRIG && (state != ST_IDLE);

   // cnt holds the remaining cycles of the current phase minus one.
   always_ff @(posedge Clk_In or posedge Rst) begin
      if (Rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         Pulse_Out <= 1'b0;
         Busy      <= 1'b0;
      end else if (load) begin
         Busy <= 1'b1;
         if (DLY_ZERO) begin
            state     <= ST_ACTIVE;
            cnt       <= LEN_LOAD;
            Pulse_Out <= 1'b1;
         end else begin
            state     <= ST_DELAY;
            cnt       <= DLY_LOAD;
            Pulse_Out <= 1'b0;
         end
      end else begin
         case (state)
            ST_DELAY: begin
               if (cnt == '0) begin
                  state     <= ST_ACTIVE;
                  cnt       <= LEN_LOAD;
                  Pulse_Out <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_ACTIVE: begin
               if (cnt == '0) begin
                  state     <= ST_IDLE;
                  Pulse_Out <= 1'b0;
                  Busy      <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               cnt       <= '0;
               Pulse_Out <= 1'b0;
               Busy      <= 1'b0;
            end
         endcase
      end
   end

   // A new drop outranks a simultaneous clear.
   always_ff @(posedge Clk_In or posedge Rst) begin
      if (Rst) begin
         Drop_Flag <= 1'b0;
      end else if (drop_set) begin
         Drop_Flag <= 1'b1;
      end else if (Flag_Clr) begin
         Drop_Flag <= 1'b0;
      end
   end

endmodule : cmd_pulse_chan

// File: rtl/cmd_multi_pulse_gen.sv
// N_CH independent command-triggered pulse channels sharing one command bus.
// Each channel reacts one edge after a hit; no backpressure, commands are never stalled.
module cmd_multi_pulse_gen
   import cmd_pulse_pkg::*;
#(
   parameter int                      CMD_W       = 16,
   parameter int                      N_CH        = 4,
   parameter int                      CNT_W       = 8,
   parameter logic [N_CH*CMD_W-1:0]   CMD_TABLE   = {16'h0003, 16'h0002, 16'h0001, 16'h0000},
   parameter logic [N_CH*CNT_W-1:0]   LEN_TABLE   = {4{8'd10}},
   parameter logic [N_CH*CNT_W-1:0]   DLY_TABLE   = {4{8'd0}},
   parameter logic [N_CH-1:0]         RETRIG_MASK = 4'b0000
) (
   input  logic             Clk_In,
   input  logic             Rst,
   input  logic [CMD_W-1:0] Cmd_In,
   input  logic             Cmd_En,
   input  logic             Flag_Clr,
   output logic [N_CH-1:0]  Pulse_Out,
   output logic [N_CH-1:0]  Busy,
   output logic [N_CH-1:0]  Drop_Flag
);

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      cmd_pulse_chan #(
         .CMD_W  (CMD_W),
         .CNT_W  (CNT_W),
         .CODE   (CMD_TABLE[gi*CMD_W +: CMD_W]),
         .LEN    (LEN_TABLE[gi*CNT_W +: CNT_W]),
         .DLY    (DLY_TABLE[gi*CNT_W +: CNT_W]),
         .RETRIG (RETRIG_MASK[gi])
      ) u_chan (
         .Clk_In    (Clk_In),
         .Rst       (Rst),
         .Cmd_In    (Cmd_In),
         .Cmd_En    (Cmd_En),
         .Flag_Clr  (Flag_Clr),
         .Pulse_Out (Pulse_Out[gi]),
         .Busy      (Busy[gi]),
         .Drop_Flag (Drop_Flag[gi])
      );
   end

endmodule : cmd_multi_pulse_gen

// File: tb/tb_cmd_multi_pulse_gen.sv
// Bench for cmd_multi_pulse_gen: a default instance and a tuned instance checked every cycle
// against a timestamp model (busy/pulse intervals per channel) plus directed expectations.
module tb_cmd_multi_pulse_gen;

   logic        Clk_In;
   logic        Rst;
   logic [15:0] Cmd_In;
   logic        Cmd_En;
   logic        Flag_Clr;
   logic [3:0]  a_pulse, a_busy, a_drop;
   logic [3:0]  b_pulse, b_busy, b_drop;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Channel tables, index [dut][channel]; dut 0 = defaults, dut 1 = tuned.
   int m_code   [2][4];
   int m_len    [2][4];
   int m_dly    [2][4];
   int m_retrig [2][4];
   // Model: busy over [m_bs, m_stop), pulse over [m_st, m_stop), in cycle numbers.
   int m_bs     [2][4];
   int m_st     [2][4];
   int m_stop   [2][4];
   bit m_drop   [2][4];
   int hi       [2][4];

   cmd_multi_pulse_gen dut_a (
      .Clk_In    (Clk_In),
      .Rst       (Rst),
      .Cmd_In    (Cmd_In),
      .Cmd_En    (Cmd_En),
      .Flag_Clr  (Flag_Clr),
      .Pulse_Out (a_pulse),
      .Busy      (a_busy),
      .Drop_Flag (a_drop)
   );

   cmd_multi_pulse_gen #(
      .CMD_TABLE   ({16'h0003, 16'h0001, 16'h0001, 16'h0000}),
      .LEN_TABLE   ({8'd10, 8'd255, 8'd10, 8'd0}),
      .DLY_TABLE   ({8'd0, 8'd2, 8'd3, 8'd0}),
      .RETRIG_MASK (4'b1100)
   ) dut_b (
      .Clk_In    (Clk_In),
      .Rst       (Rst),
      .Cmd_In    (Cmd_In),
      .Cmd_En    (Cmd_En),
      .Flag_Clr  (Flag_Clr),
      .Pulse_Out (b_pulse),
      .Busy      (b_busy),
      .Drop_Flag (b_drop)
   );

   initial Clk_In = 1'b0;
   always #5 Clk_In = ~Clk_In;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            m_bs[d][c]   = 0;
            m_st[d][c]   = 0;
            m_stop[d][c] = 0;
            m_drop[d][c] = 1'b0;
         end
   endtask

   task automatic clr_hi();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) hi[d][c] = 0;
   endtask

   // Apply the inputs of the current cycle to the model.
   task automatic model_step(input bit en, input logic [15:0] cmd, input bit clr);
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            bit hit;
            bit busy;
            bit set;
            int leff;
            hit  = en && (cmd == 16'(m_code[d][c]));
            leff = (m_len[d][c] == 0) ? 1 : m_len[d][c];
            busy = (cyc >= m_bs[d][c]) && (cyc < m_stop[d][c]);
            set  = 1'b0;
            if (hit) begin
               if (!busy) begin
                  m_bs[d][c]   = cyc + 1;
                  m_st[d][c]   = cyc + 1 + m_dly[d][c];
                  m_stop[d][c] = m_st[d][c] + leff;
               end else if (m_retrig[d][c] != 0) begin
                  if (m_dly[d][c] == 0) begin
                     if (cyc < m_st[d][c]) m_st[d][c] = cyc + 1;
                     m_stop[d][c] = cyc + 1 + leff;
                  end else begin
                     m_st[d][c]   = cyc + 1 + m_dly[d][c];
                     m_stop[d][c] = m_st[d][c] + leff;
                  end
               end else begin
                  set = 1'b1;
               end
            end
            if (set) m_drop[d][c] = 1'b1;
            else if (clr) m_drop[d][c] = 1'b0;
         end
   endtask

   task automatic check_outputs();
      logic [3:0] ep [2];
      logic [3:0] eb [2];
      logic [3:0] ed [2];
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            ep[d][c] = (cyc >= m_st[d][c]) && (cyc < m_stop[d][c]);
            eb[d][c] = (cyc >= m_bs[d][c]) && (cyc < m_stop[d][c]);
            ed[d][c] = m_drop[d][c];
         end
      for (int c = 0; c < 4; c++) begin
         hi[0][c] += int'(a_pulse[c]);
         hi[1][c] += int'(b_pulse[c]);
      end
      chk("a_pulse", 32'(a_pulse), 32'(ep[0]));
      chk("a_busy",  32'(a_busy),  32'(eb[0]));
      chk("a_drop",  32'(a_drop),  32'(ed[0]));
      chk("b_pulse", 32'(b_pulse), 32'(ep[1]));
      chk("b_busy",  32'(b_busy),  32'(eb[1]));
      chk("b_drop",  32'(b_drop),  32'(ed[1]));
   endtask

   task automatic cycle(input bit en, input logic [15:0] cmd, input bit clr);
      Cmd_En   = en;
      Cmd_In   = cmd;
      Flag_Clr = clr;
      model_step(en, cmd, clr);
      @(posedge Clk_In);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 16'($urandom), 1'b0);
   endtask

   // Assert reset between edges, check the asynchronous clear, release before the next edge.
   task automatic do_reset(input int hold);
      Cmd_En   = 1'b0;
      Flag_Clr = 1'b0;
      Rst      = 1'b1;
      #1;
      chk("rst_a_pulse", 32'(a_pulse), 32'd0);
      chk("rst_a_busy",  32'(a_busy),  32'd0);
      chk("rst_a_drop",  32'(a_drop),  32'd0);
      chk("rst_b_pulse", 32'(b_pulse), 32'd0);
      chk("rst_b_busy",  32'(b_busy),  32'd0);
      chk("rst_b_drop",  32'(b_drop),  32'd0);
      model_reset();
      repeat (hold) begin
         @(posedge Clk_In);
         #1;
         cyc++;
         check_outputs();
      end
      Rst = 1'b0;
   endtask

   initial begin
      int sum;
      m_code   = '{'{0, 1, 2, 3},     '{0, 1, 1, 3}};
      m_len    = '{'{10, 10, 10, 10}, '{0, 10, 255, 10}};
      m_dly    = '{'{0, 0, 0, 0},     '{0, 3, 2, 0}};
      m_retrig = '{'{0, 0, 0, 0},     '{0, 0, 1, 1}};
      model_reset();
      clr_hi();
      Rst      = 1'b1;
      Cmd_En   = 1'b0;
      Cmd_In   = 16'h0000;
      Flag_Clr = 1'b0;
      @(posedge Clk_In);
      #1;
      cyc++;
      do_reset(2);

      // Single default pulse on channel 0; tuned channel 0 has LEN=0.
      clr_hi();
      cycle(1'b1, 16'h0000, 1'b0);
      chk("ch0_first_edge", 32'(a_pulse), 32'h1);
      idle(14);
      chk("ch0_len10", hi[0][0], 10);
      chk("ch0_others", hi[0][1] + hi[0][2] + hi[0][3], 0);
      chk("len0_is_1", hi[1][0], 1);

      // Delayed start on tuned channel 1 (DLY=3), shared code with channel 2.
      clr_hi();
      cycle(1'b1, 16'h0001, 1'b0);
      chk("dly_busy_rise", 32'(b_busy[1]), 32'h1);
      chk("dly_no_pulse", 32'(b_pulse[1]), 32'h0);
      idle(2);
      chk("dly_pulse_c3", 32'(b_pulse[1]), 32'h0);
      idle(1);
      chk("dly_pulse_c4", 32'(b_pulse[1]), 32'h1);
      idle(15);
      chk("dly_len10", hi[1][1], 10);
      idle(260);
      chk("len255", hi[1][2], 255);

      // Ignored retrigger sets the sticky drop flag.
      clr_hi();
      cycle(1'b1, 16'h0002, 1'b0);
      idle(4);
      cycle(1'b1, 16'h0002, 1'b0);
      idle(12);
      chk("drop_len10", hi[0][2], 10);
      chk("drop_set", 32'(a_drop[2]), 32'h1);
      cycle(1'b0, 16'h0000, 1'b1);
      chk("drop_clr", 32'(a_drop[2]), 32'h0);
      cycle(1'b1, 16'h0002, 1'b0);
      idle(2);
      cycle(1'b1, 16'h0002, 1'b1);
      chk("drop_set_wins", 32'(a_drop[2]), 32'h1);
      idle(12);

      // Retrigger extends channel 3 on the tuned instance; default instance drops it.
      clr_hi();
      cycle(1'b1, 16'h0003, 1'b0);
      idle(4);
      cycle(1'b1, 16'h0003, 1'b0);
      idle(16);
      chk("retrig_len15", hi[1][3], 15);
      chk("retrig_nodrop", 32'(b_drop[3]), 32'h0);
      chk("noretrig_len10", hi[0][3], 10);
      chk("noretrig_drop", 32'(a_drop[3]), 32'h1);

      // Reset mid-pulse, then a fresh full pulse.
      clr_hi();
      cycle(1'b1, 16'h0000, 1'b0);
      idle(3);
      chk("pre_rst_pulse", 32'(a_pulse[0]), 32'h1);
      do_reset(2);
      idle(1);
      clr_hi();
      cycle(1'b1, 16'h0000, 1'b0);
      idle(12);
      chk("post_rst_len10", hi[0][0], 10);

      // Hit on the very first edge after release.
      do_reset(1);
      cycle(1'b1, 16'h0003, 1'b0);
      chk("first_edge_a", 32'(a_pulse[3]), 32'h1);
      chk("first_edge_b", 32'(b_pulse[3]), 32'h1);
      idle(12);

      // Non-matching command does nothing; then LEN=0 gives one cycle.
      clr_hi();
      cycle(1'b1, 16'h0005, 1'b0);
      idle(3);
      sum = 0;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) sum += hi[d][c];
      chk("nohit_quiet", sum, 0);
      chk("nohit_busy", 32'({a_busy, b_busy}), 32'h0);
      clr_hi();
      cycle(1'b1, 16'h0000, 1'b0);
      idle(3);
      chk("len0_single", hi[1][0], 1);

      // Randomised traffic, including occasional asynchronous resets.
      for (int i = 0; i < 4000; i++) begin
         bit          en;
         bit          clr;
         logic [15:0] cmd;
         if ($urandom_range(0, 599) == 0) do_reset(int'($urandom_range(0, 2)));
         en  = ($urandom_range(0, 6) == 0);
         clr = ($urandom_range(0, 15) == 0);
         cmd = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
         cycle(en, cmd, clr);
      end
      idle(300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cmd_multi_pulse_gen
